// File: rtl/pipeline_data_path.sv
// Five-stage MIPS-style datapath: fetch, decode, execute, memory, write-back.
// Handles forwarding, load-use and branch stalls. Control signals come from an external decoder.
module pipeline_data_path #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter              IMEM_FILE  = "imem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_d,
  input  logic        regdst_d,
  input  logic        alusrc_d,
  input  logic [3:0]  aluctrl_d,
  input  logic        memwrite_d,
  input  logic        memtoreg_d,
  input  logic        se_ze,
  input  logic [1:0]  outselect_d,
  input  logic        start_mult,
  input  logic        mult_sign,
  input  logic        output_branch,
  input  logic [1:0]  pcsrc,
  output logic        eq_ne,
  output logic [5:0]  op_code,
  output logic [5:0]  control_unit_funct,
  output logic [31:0] result_w
);

  typedef struct packed {
    logic        regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [3:0]  aluctrl;
    logic [1:0]  outselect;
    logic        start_mult, mult_sign;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd, shamt;
  } idex_t;

  typedef struct packed {
    logic        regwrite, memtoreg, memwrite;
    logic [31:0] aluout, writedata;
    logic [4:0]  writereg;
  } exmem_t;

  typedef struct packed {
    logic        regwrite, memtoreg;
    logic [31:0] readdata, aluout;
    logic [4:0]  writereg;
  } memwb_t;

  // The instruction ROM is loaded by the environment; it has no reset.
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  logic [31:0] pc_q, pc_next, pcplus4_f, instr_f;
  logic [31:0] instr_d, pcplus4_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [31:0] sext_imm_d, imm_ext_d, rd1_d, rd2_d, fwd_rs_d, fwd_rt_d;
  logic        lw_stall, br_stall, stall, branch_d;

  idex_t       idex_d, idex_q;
  exmem_t      exmem_d, exmem_q;
  memwb_t      memwb_d, memwb_q;

  logic [31:0] src_a_e, wdata_e, src_b_e, alu_e, result_e;
  logic [63:0] mul_a_e, mul_b_e, product_e;
  logic [31:0] hi_q, lo_q;
  logic [4:0]  writereg_e;
  logic [31:0] readdata_m;

  // Fetch
  assign instr_f   = imem[pc_q[7:2]];
  assign pcplus4_f = pc_q + 32'd4;

  always_comb begin
    pc_next = pcplus4_f;
    case (pcsrc)
      2'b01:   pc_next = pcplus4_d + {sext_imm_d[29:0], 2'b00};
      2'b10:   pc_next = {pcplus4_d[31:28], instr_d[25:0], 2'b00};
      2'b11:   pc_next = fwd_rs_d;
      default: pc_next = pcplus4_f;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      instr_d   <= '0;
      pcplus4_d <= '0;
    end else if (!stall) begin
      pc_q      <= pc_next;
      instr_d   <= instr_f;
      pcplus4_d <= pcplus4_f;
    end
  end

  // Decode
  assign op_code            = instr_d[31:26];
  assign control_unit_funct = instr_d[5:0];
  assign rs_d               = instr_d[25:21];
  assign rt_d               = instr_d[20:16];
  assign rd_d               = instr_d[15:11];
  assign sext_imm_d         = {{16{instr_d[15]}}, instr_d[15:0]};
  assign imm_ext_d          = se_ze ? sext_imm_d : {16'b0, instr_d[15:0]};
  assign rd1_d              = (rs_d == 5'd0) ? '0 : rf[rs_d];
  assign rd2_d              = (rt_d == 5'd0) ? '0 : rf[rt_d];

  assign fwd_rs_d = (rs_d != 5'd0 && exmem_q.regwrite && rs_d == exmem_q.writereg)
                    ? exmem_q.aluout : rd1_d;
  assign fwd_rt_d = (rt_d != 5'd0 && exmem_q.regwrite && rt_d == exmem_q.writereg)
                    ? exmem_q.aluout : rd2_d;
  assign eq_ne    = (fwd_rs_d == fwd_rt_d);

  // Branches resolve in D, so producers still in E (or loads in M) must be waited on.
  assign branch_d = output_branch || (pcsrc == 2'b11);
  assign lw_stall = idex_q.memtoreg && (writereg_e != 5'd0) &&
                    (rs_d == writereg_e || rt_d == writereg_e);
  assign br_stall = branch_d &&
                    ((idex_q.regwrite && writereg_e != 5'd0 &&
                      (rs_d == writereg_e || rt_d == writereg_e)) ||
                     (exmem_q.memtoreg && exmem_q.writereg != 5'd0 &&
                      (rs_d == exmem_q.writereg || rt_d == exmem_q.writereg)));
  assign stall    = lw_stall || br_stall;

  always_comb begin
    idex_d = '0;
    if (!stall) begin
      idex_d.regwrite   = regwrite_d;
      idex_d.memtoreg   = memtoreg_d;
      idex_d.memwrite   = memwrite_d;
      idex_d.alusrc     = alusrc_d;
      idex_d.regdst     = regdst_d;
      idex_d.aluctrl    = aluctrl_d;
      idex_d.outselect  = outselect_d;
      idex_d.start_mult = start_mult;
      idex_d.mult_sign  = mult_sign;
      idex_d.rd1        = rd1_d;
      idex_d.rd2        = rd2_d;
      idex_d.imm        = imm_ext_d;
      idex_d.rs         = rs_d;
      idex_d.rt         = rt_d;
      idex_d.rd         = rd_d;
      idex_d.shamt      = instr_d[10:6];
    end
  end

  // Register file writes on the falling edge so D reads see same-cycle W writes.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (memwb_q.regwrite && memwb_q.writereg != 5'd0) begin
      rf[memwb_q.writereg] <= result_w;
    end
  end

  // Execute
  always_comb begin
    src_a_e = idex_q.rd1;
    if (idex_q.rs != 5'd0 && exmem_q.regwrite && idex_q.rs == exmem_q.writereg) begin
      src_a_e = exmem_q.aluout;
    end else if (idex_q.rs != 5'd0 && memwb_q.regwrite && idex_q.rs == memwb_q.writereg) begin
      src_a_e = result_w;
    end
    wdata_e = idex_q.rd2;
    if (idex_q.rt != 5'd0 && exmem_q.regwrite && idex_q.rt == exmem_q.writereg) begin
      wdata_e = exmem_q.aluout;
    end else if (idex_q.rt != 5'd0 && memwb_q.regwrite && idex_q.rt == memwb_q.writereg) begin
      wdata_e = result_w;
    end
  end

  assign src_b_e = idex_q.alusrc ? idex_q.imm : wdata_e;

  always_comb begin
    case (idex_q.aluctrl)
      4'b0000: alu_e = src_a_e & src_b_e;
      4'b0001: alu_e = src_a_e | src_b_e;
      4'b0010: alu_e = src_a_e ^ src_b_e;
      4'b0011: alu_e = ~(src_a_e | src_b_e);
      4'b0100: alu_e = src_a_e + src_b_e;
      4'b0110: alu_e = src_a_e - src_b_e;
      4'b0111: alu_e = {31'b0, $signed(src_a_e) < $signed(src_b_e)};
      4'b1000: alu_e = {31'b0, src_a_e < src_b_e};
      4'b1001: alu_e = src_b_e << idex_q.shamt;
      4'b1010: alu_e = src_b_e >> idex_q.shamt;
      4'b1011: alu_e = $unsigned($signed(src_b_e) >>> idex_q.shamt);
      default: alu_e = '0;
    endcase
  end

  // Low 64 bits of the extended product are correct for both signed and unsigned.
  assign mul_a_e   = {{32{idex_q.mult_sign & src_a_e[31]}}, src_a_e};
  assign mul_b_e   = {{32{idex_q.mult_sign & src_b_e[31]}}, src_b_e};
  assign product_e = mul_a_e * mul_b_e;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (idex_q.start_mult) begin
      hi_q <= product_e[63:32];
      lo_q <= product_e[31:0];
    end
  end

  always_comb begin
    case (idex_q.outselect)
      2'b01:   result_e = hi_q;
      2'b10:   result_e = lo_q;
      2'b11:   result_e = {idex_q.imm[15:0], 16'b0};
      default: result_e = alu_e;
    endcase
  end

  assign writereg_e = idex_q.regdst ? idex_q.rd : idex_q.rt;

  always_comb begin
    exmem_d           = '0;
    exmem_d.regwrite  = idex_q.regwrite;
    exmem_d.memtoreg  = idex_q.memtoreg;
    exmem_d.memwrite  = idex_q.memwrite;
    exmem_d.aluout    = result_e;
    exmem_d.writedata = wdata_e;
    exmem_d.writereg  = writereg_e;
  end

  // Memory
  assign readdata_m = dmem[exmem_q.aluout[7:2]];

  always_ff @(posedge clk) begin
    if (exmem_q.memwrite) dmem[exmem_q.aluout[7:2]] <= exmem_q.writedata;
  end

  always_comb begin
    memwb_d          = '0;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.readdata = readdata_m;
    memwb_d.aluout   = exmem_q.aluout;
    memwb_d.writereg = exmem_q.writereg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Write-back
  assign result_w = memwb_q.memtoreg ? memwb_q.readdata : memwb_q.aluout;

endmodule

// File: tb/tb_pipeline_data_path.sv
// Bench for pipeline_data_path: acts as the instruction decoder, runs directed programs,
// then a random ALU program checked against an instruction-level reference model.
module tb_pipeline_data_path;

  localparam int NRAND = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_d, regdst_d, alusrc_d, memwrite_d, memtoreg_d, se_ze;
  logic [3:0]  aluctrl_d;
  logic [1:0]  outselect_d, pcsrc;
  logic        start_mult, mult_sign, output_branch;
  logic        eq_ne;
  logic [5:0]  op_code, control_unit_funct;
  logic [31:0] result_w;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          edge_n   = 0;
  logic [31:0] prog [64];

  always #5 clk = ~clk;

  pipeline_data_path dut (
    .clk                (clk),
    .reset              (reset),
    .regwrite_d         (regwrite_d),
    .regdst_d           (regdst_d),
    .alusrc_d           (alusrc_d),
    .aluctrl_d          (aluctrl_d),
    .memwrite_d         (memwrite_d),
    .memtoreg_d         (memtoreg_d),
    .se_ze              (se_ze),
    .outselect_d        (outselect_d),
    .start_mult         (start_mult),
    .mult_sign          (mult_sign),
    .output_branch      (output_branch),
    .pcsrc              (pcsrc),
    .eq_ne              (eq_ne),
    .op_code            (op_code),
    .control_unit_funct (control_unit_funct),
    .result_w           (result_w)
  );

  // Instruction decoder standing in for the external control unit.
  always_comb begin
    {regwrite_d, regdst_d, alusrc_d, aluctrl_d, memwrite_d, memtoreg_d, se_ze,
     outselect_d, start_mult, mult_sign, output_branch, pcsrc} = '0;
    case (op_code)
      6'h00: begin
        regwrite_d = 1'b1;
        regdst_d   = 1'b1;
        case (control_unit_funct)
          6'h00:       aluctrl_d = 4'b1001;
          6'h02:       aluctrl_d = 4'b1010;
          6'h03:       aluctrl_d = 4'b1011;
          6'h08:       begin regwrite_d = 1'b0; pcsrc = 2'b11; end
          6'h10:       outselect_d = 2'b01;
          6'h12:       outselect_d = 2'b10;
          6'h18:       begin regwrite_d = 1'b0; start_mult = 1'b1; mult_sign = 1'b1; end
          6'h19:       begin regwrite_d = 1'b0; start_mult = 1'b1; end
          6'h20, 6'h21: aluctrl_d = 4'b0100;
          6'h22, 6'h23: aluctrl_d = 4'b0110;
          6'h24:       aluctrl_d = 4'b0000;
          6'h25:       aluctrl_d = 4'b0001;
          6'h26:       aluctrl_d = 4'b0010;
          6'h27:       aluctrl_d = 4'b0011;
          6'h2a:       aluctrl_d = 4'b0111;
          6'h2b:       aluctrl_d = 4'b1000;
          default:     regwrite_d = 1'b0;
        endcase
      end
      6'h02: pcsrc = 2'b10;
      6'h04: begin output_branch = 1'b1; aluctrl_d = 4'b0110; pcsrc = eq_ne ? 2'b01 : 2'b00; end
      6'h05: begin output_branch = 1'b1; aluctrl_d = 4'b0110; pcsrc = eq_ne ? 2'b00 : 2'b01; end
      6'h08: begin regwrite_d = 1'b1; alusrc_d = 1'b1; se_ze = 1'b1; aluctrl_d = 4'b0100; end
      6'h0a: begin regwrite_d = 1'b1; alusrc_d = 1'b1; se_ze = 1'b1; aluctrl_d = 4'b0111; end
      6'h0b: begin regwrite_d = 1'b1; alusrc_d = 1'b1; se_ze = 1'b1; aluctrl_d = 4'b1000; end
      6'h0c: begin regwrite_d = 1'b1; alusrc_d = 1'b1; aluctrl_d = 4'b0000; end
      6'h0d: begin regwrite_d = 1'b1; alusrc_d = 1'b1; aluctrl_d = 4'b0001; end
      6'h0e: begin regwrite_d = 1'b1; alusrc_d = 1'b1; aluctrl_d = 4'b0010; end
      6'h0f: begin regwrite_d = 1'b1; alusrc_d = 1'b1; outselect_d = 2'b11; end
      6'h23: begin
        regwrite_d = 1'b1; alusrc_d = 1'b1; se_ze = 1'b1; aluctrl_d = 4'b0100;
        memtoreg_d = 1'b1;
      end
      6'h2b: begin alusrc_d = 1'b1; se_ze = 1'b1; aluctrl_d = 4'b0100; memwrite_d = 1'b1; end
      default: ;
    endcase
  end

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
  endtask

  // Hold reset for two cycles, check reset state, load the ROM, release on a falling edge.
  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result_w", result_w, 32'd0);
    check("rst_op_code", 32'(op_code), 32'd0);
    check("rst_funct", 32'(control_unit_funct), 32'd0);
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  initial begin
    logic [31:0]        mregs [32];
    logic [31:0]        exp_r [NRAND];
    logic [31:0]        ra, rb, rse, rze, rval;
    logic signed [31:0] rsb;
    logic [4:0]         rrs, rrt, rrd, rsh, rdst;
    logic [15:0]        rimm;
    int                 pick;

    reset = 1'b0;

    // Reset, first fetch and a plain ADD.
    clear_prog();
    prog[0] = r_ins(6'h20, 5'd0, 5'd0, 5'd3, 5'd0);
    prog[1] = i_ins(6'h0d, 5'd0, 5'd7, 16'h1234);
    apply_reset();
    step_to(1);
    check("first_op_code", 32'(op_code), 32'h00);
    check("first_funct", 32'(control_unit_funct), 32'h20);
    @(negedge clk);
    check("funct_stable", 32'(control_unit_funct), 32'h20);
    step_to(2);
    check("second_op_code", 32'(op_code), 32'h0d);
    check("second_funct", 32'(control_unit_funct), 32'h34);
    step_to(4);
    check("add_zero_wb", result_w, 32'd0);
    step_to(5);
    check("ori_wb", result_w, 32'h0000_1234);
    #2 reset = 1'b0;
    #1 check("async_reset_result_w", result_w, 32'd0);

    // Forwarding from M and W, then a load-use hazard costing one bubble.
    clear_prog();
    prog[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd7);
    prog[2] = r_ins(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
    prog[3] = i_ins(6'h2b, 5'd0, 5'd2, 16'd0);
    prog[4] = i_ins(6'h23, 5'd0, 5'd4, 16'd0);
    prog[5] = r_ins(6'h20, 5'd4, 5'd4, 5'd5, 5'd0);
    prog[6] = i_ins(6'h08, 5'd0, 5'd6, 16'd1);
    apply_reset();
    step_to(4);  check("addi1_wb", result_w, 32'd5);
    step_to(5);  check("addi2_wb", result_w, 32'd7);
    step_to(6);  check("fwd_add_wb", result_w, 32'd12);
    step_to(8);  check("lw_wb", result_w, 32'd7);
    step_to(10); check("load_use_add_wb", result_w, 32'd14);
    step_to(11); check("after_stall_wb", result_w, 32'd1);

    // Signed and unsigned multiply read back through MFHI/MFLO.
    clear_prog();
    prog[0] = i_ins(6'h08, 5'd0, 5'd1, 16'hfffe);
    prog[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd3);
    prog[2] = r_ins(6'h18, 5'd1, 5'd2, 5'd0, 5'd0);
    prog[3] = r_ins(6'h10, 5'd0, 5'd0, 5'd3, 5'd0);
    prog[4] = r_ins(6'h12, 5'd0, 5'd0, 5'd4, 5'd0);
    prog[5] = i_ins(6'h08, 5'd0, 5'd5, 16'hffff);
    prog[6] = i_ins(6'h08, 5'd0, 5'd6, 16'd2);
    prog[7] = r_ins(6'h19, 5'd5, 5'd6, 5'd0, 5'd0);
    prog[8] = r_ins(6'h10, 5'd0, 5'd0, 5'd7, 5'd0);
    prog[9] = r_ins(6'h12, 5'd0, 5'd0, 5'd8, 5'd0);
    apply_reset();
    step_to(7);  check("mult_hi", result_w, 32'hffff_ffff);
    step_to(8);  check("mult_lo", result_w, 32'hffff_fffa);
    step_to(12); check("multu_hi", result_w, 32'h0000_0001);
    step_to(13); check("multu_lo", result_w, 32'hffff_fffe);

    // Taken branch with delay slot; writes to $0 are discarded.
    clear_prog();
    prog[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd1);
    prog[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd2);
    prog[2] = i_ins(6'h04, 5'd1, 5'd1, 16'd2);
    prog[3] = i_ins(6'h08, 5'd0, 5'd3, 16'd3);
    prog[4] = i_ins(6'h08, 5'd0, 5'd4, 16'd4);
    prog[5] = i_ins(6'h08, 5'd0, 5'd0, 16'd9);
    prog[6] = r_ins(6'h20, 5'd1, 5'd0, 5'd6, 5'd0);
    prog[7] = r_ins(6'h20, 5'd0, 5'd3, 5'd7, 5'd0);
    apply_reset();
    step_to(3);  check("beq_eq_ne", 32'(eq_ne), 32'd1);
    step_to(7);  check("delay_slot_wb", result_w, 32'd3);
    step_to(8);  check("target_wb", result_w, 32'd9);
    step_to(9);  check("r0_as_rt_wb", result_w, 32'd1);
    step_to(10); check("r0_as_rs_wb", result_w, 32'd3);
    step_to(11);
    check("r0_stays_zero", dut.rf[0], 32'd0);
    check("skipped_instr_reg", dut.rf[4], 32'd0);

    // Random ALU program against an instruction-level model; no loads or branches.
    clear_prog();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    for (int k = 0; k < NRAND; k++) begin
      pick = int'($urandom_range(0, 18));
      rrs  = 5'($urandom_range(0, 7));
      rrt  = 5'($urandom_range(0, 7));
      rrd  = 5'($urandom_range(0, 7));
      rsh  = 5'($urandom_range(0, 31));
      rimm = 16'($urandom);
      ra   = mregs[rrs];
      rb   = mregs[rrt];
      rse  = {{16{rimm[15]}}, rimm};
      rze  = {16'd0, rimm};
      rsb  = rb;
      rdst = rrd;
      case (pick)
        0:  begin prog[k] = r_ins(6'h20, rrs, rrt, rrd, 5'd0); rval = ra + rb; end
        1:  begin prog[k] = r_ins(6'h22, rrs, rrt, rrd, 5'd0); rval = ra - rb; end
        2:  begin prog[k] = r_ins(6'h24, rrs, rrt, rrd, 5'd0); rval = ra & rb; end
        3:  begin prog[k] = r_ins(6'h25, rrs, rrt, rrd, 5'd0); rval = ra | rb; end
        4:  begin prog[k] = r_ins(6'h26, rrs, rrt, rrd, 5'd0); rval = ra ^ rb; end
        5:  begin prog[k] = r_ins(6'h27, rrs, rrt, rrd, 5'd0); rval = ~(ra | rb); end
        6:  begin
          prog[k] = r_ins(6'h2a, rrs, rrt, rrd, 5'd0);
          rval = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
        end
        7:  begin prog[k] = r_ins(6'h2b, rrs, rrt, rrd, 5'd0); rval = (ra < rb) ? 32'd1 : 32'd0; end
        8:  begin prog[k] = r_ins(6'h00, 5'd0, rrt, rrd, rsh); rval = rb << rsh; end
        9:  begin prog[k] = r_ins(6'h02, 5'd0, rrt, rrd, rsh); rval = rb >> rsh; end
        10: begin prog[k] = r_ins(6'h03, 5'd0, rrt, rrd, rsh); rval = rsb >>> rsh; end
        11: begin prog[k] = i_ins(6'h08, rrs, rrd, rimm); rval = ra + rse; end
        12: begin
          prog[k] = i_ins(6'h0a, rrs, rrd, rimm);
          rval = ($signed(ra) < $signed(rse)) ? 32'd1 : 32'd0;
        end
        13: begin prog[k] = i_ins(6'h0b, rrs, rrd, rimm); rval = (ra < rse) ? 32'd1 : 32'd0; end
        14: begin prog[k] = i_ins(6'h0c, rrs, rrd, rimm); rval = ra & rze; end
        15: begin prog[k] = i_ins(6'h0d, rrs, rrd, rimm); rval = ra | rze; end
        16: begin prog[k] = i_ins(6'h0e, rrs, rrd, rimm); rval = ra ^ rze; end
        17: begin prog[k] = i_ins(6'h0f, 5'd0, rrd, rimm); rval = {rimm, 16'd0}; end
        default: begin prog[k] = r_ins(6'h21, rrs, rrt, rrd, 5'd0); rval = ra + rb; end
      endcase
      exp_r[k] = rval;
      if (rdst != 5'd0) mregs[rdst] = rval;
    end
    apply_reset();
    for (int e = 1; e <= NRAND + 3; e++) begin
      step_to(e);
      if (e >= 4) check($sformatf("rand_wb[%0d]", e - 4), result_w, exp_r[e - 4]);
    end
    step_to(NRAND + 5);
    for (int i = 0; i < 8; i++) check($sformatf("rand_reg[%0d]", i), dut.rf[i], mregs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
